apb_monitor: RTL and testbench

APB_MONITOR -- requirements
Module: apb_monitor

---
 rtl/apb_monitor_pkg.sv | 34 +++
 rtl/apb_monitor_syncFifo.sv | 52 +++++
 rtl/apb_monitor.sv | 179 +++++++++++++++++
 tb/tb_apb_monitor.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_monitor_pkg.sv
// Shared types for the passive APB bus monitor.
// Holds the phase tracker states, violation codes and the record header.
package apb_monitor_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_ACCESS
   } state_e;

   typedef enum logic [2:0] {
      ERR_NONE      = 3'd0,
      ERR_NO_SETUP  = 3'd1,
      ERR_NO_ACCESS = 3'd2,
      ERR_FIELD     = 3'd3,
      ERR_DROP      = 3'd4,
      ERR_TIMEOUT   = 3'd5
   } err_e;

   // Fixed-width part of a record; addr/data/strb travel beside it.
   typedef struct packed {
      logic       write;
      logic [2:0] prot;
      logic       slverr;
      logic [7:0] waits;
   } rec_t;

   localparam int REC_W = $bits(rec_t);

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/apb_monitor_syncFifo.sv
// Record FIFO for the APB monitor.
// Power-of-two depth; a push into a full FIFO is taken only alongside a pop.
module syncFifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             arst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [PW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (PW+1)'(DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         unique case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/apb_monitor.sv
// Passive APB monitor: checks phase protocol, records completed
// transfers into a FIFO and keeps sticky error/overflow flags.
module apb_monitor
   import apb_monitor_pkg::*;
#(
   parameter int AWIDTH  = 12,
   parameter int DWIDTH  = 32,
   parameter int SWIDTH  = 4,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 255
) (
   input  logic              i_clk,
   input  logic              i_arst,
   input  logic              i_sel,
   input  logic              i_enable,
   input  logic              i_write,
   input  logic [AWIDTH-1:0] i_addr,
   input  logic [DWIDTH-1:0] i_wdata,
   input  logic [DWIDTH-1:0] i_rdata,
   input  logic [SWIDTH-1:0] i_strb,
   input  logic [2:0]        i_prot,
   input  logic              i_ready,
   input  logic              i_slverr,
   input  logic              i_pop,
   input  logic              i_clrErr,
   output logic              o_valid,
   output logic              o_recWrite,
   output logic [AWIDTH-1:0] o_recAddr,
   output logic [DWIDTH-1:0] o_recData,
   output logic [SWIDTH-1:0] o_recStrb,
   output logic [2:0]        o_recProt,
   output logic              o_recSlvErr,
   output logic [7:0]        o_recWaits,
   output logic              o_err,
   output logic [2:0]        o_errCode,
   output logic              o_overflow,
   output logic [15:0]       o_txnCount
);

   localparam int FW = REC_W + SWIDTH + AWIDTH + DWIDTH;

   state_e            state, state_n;
   logic [7:0]        wcnt, wcnt_n;
   logic              cap_write;
   logic [AWIDTH-1:0] cap_addr;
   logic [DWIDTH-1:0] cap_wdata;
   logic [SWIDTH-1:0] cap_strb;
   logic [2:0]        cap_prot;
   logic              capture, complete, viol, same;
   err_e              viol_code, err_code;
   logic              ovf_ev, fifo_full, fifo_empty;
   rec_t              rec_in, rec_out;
   logic [FW-1:0]     fifo_in, fifo_out;
   logic [AWIDTH-1:0] head_addr;
   logic [DWIDTH-1:0] head_data;
   logic [SWIDTH-1:0] head_strb;

   assign same = (i_addr == cap_addr) && (i_write == cap_write) &&
                 (i_wdata == cap_wdata) && (i_strb == cap_strb) &&
                 (i_prot == cap_prot);

   always_comb begin
      state_n   = state;
      wcnt_n    = wcnt;
      capture   = 1'b0;
      complete  = 1'b0;
      viol      = 1'b0;
      viol_code = ERR_NONE;
      unique case (state)
         ST_IDLE: begin
            if (i_sel && !i_enable) begin
               state_n = ST_SETUP;
               capture = 1'b1;
               wcnt_n  = '0;
            end else if (i_sel && i_enable) begin
               viol      = 1'b1;
               viol_code = ERR_NO_SETUP;
            end
         end
         ST_SETUP, ST_ACCESS: begin
            if (!(i_sel && i_enable)) begin
               viol      = 1'b1;
               viol_code = (state == ST_SETUP) ? ERR_NO_ACCESS : ERR_DROP;
            end else if (!same) begin
               viol      = 1'b1;
               viol_code = ERR_FIELD;
            end else if (i_ready) begin
               complete = 1'b1;
               state_n  = ST_IDLE;
            end else begin
               wcnt_n  = sat_inc(wcnt);
               state_n = ST_ACCESS;
               if (wcnt_n >= 8'(TIMEOUT)) begin
                  viol      = 1'b1;
                  viol_code = ERR_TIMEOUT;
               end
            end
            if (viol) state_n = ST_IDLE;
         end
         default: state_n = ST_IDLE;
      endcase
   end

   // Read data is taken on the completing cycle, write data from setup.
   always_comb begin
      rec_in        = '0;
      rec_in.write  = cap_write;
      rec_in.prot   = cap_prot;
      rec_in.slverr = i_slverr;
      rec_in.waits  = wcnt;
      fifo_in = {rec_in, cap_strb, cap_addr,
                 cap_write ? cap_wdata : i_rdata};
   end

   assign ovf_ev = complete & fifo_full & ~i_pop;

   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         state      <= ST_IDLE;
         wcnt       <= '0;
         cap_write  <= 1'b0;
         cap_addr   <= '0;
         cap_wdata  <= '0;
         cap_strb   <= '0;
         cap_prot   <= '0;
         o_txnCount <= '0;
         o_err      <= 1'b0;
         err_code   <= ERR_NONE;
         o_overflow <= 1'b0;
      end else begin
         state <= state_n;
         wcnt  <= wcnt_n;
         if (capture) begin
            cap_write <= i_write;
            cap_addr  <= i_addr;
            cap_wdata <= i_wdata;
            cap_strb  <= i_strb;
            cap_prot  <= i_prot;
         end
         if (complete) o_txnCount <= o_txnCount + 16'd1;
         if (viol) begin
            o_err <= 1'b1;
            if (!o_err || i_clrErr) err_code <= viol_code;
         end else if (i_clrErr) begin
            o_err    <= 1'b0;
            err_code <= ERR_NONE;
         end
         if (ovf_ev)        o_overflow <= 1'b1;
         else if (i_clrErr) o_overflow <= 1'b0;
      end
   end

   syncFifo #(
      .WIDTH (FW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (i_clk),
      .arst  (i_arst),
      .push  (complete),
      .pop   (i_pop),
      .wdata (fifo_in),
      .rdata (fifo_out),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign {rec_out, head_strb, head_addr, head_data} = fifo_out;

   assign o_errCode   = err_code;
   assign o_valid     = ~fifo_empty;
   assign o_recWrite  = o_valid & rec_out.write;
   assign o_recSlvErr = o_valid & rec_out.slverr;
   assign o_recProt   = o_valid ? rec_out.prot  : '0;
   assign o_recWaits  = o_valid ? rec_out.waits : '0;
   assign o_recAddr   = o_valid ? head_addr     : '0;
   assign o_recData   = o_valid ? head_data     : '0;
   assign o_recStrb   = o_valid ? head_strb     : '0;

endmodule

// File: tb/tb_apb_monitor.sv
// Directed bench for apb_monitor.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_apb_monitor;

   localparam int AW      = 12;
   localparam int DW      = 32;
   localparam int SW      = 4;
   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 16;

   logic          clk = 1'b0;
   logic          arst = 1'b1;
   logic          sel = 1'b0, en = 1'b0, wr = 1'b0;
   logic [AW-1:0] addr = '0;
   logic [DW-1:0] wdata = '0, rdata = '0;
   logic [SW-1:0] strb = '0;
   logic [2:0]    prot = '0;
   logic          ready = 1'b0, slverr = 1'b0;
   logic          pop = 1'b0, clr = 1'b0;

   logic          valid, rec_write, rec_slverr, err, overflow;
   logic [AW-1:0] rec_addr;
   logic [DW-1:0] rec_data;
   logic [SW-1:0] rec_strb;
   logic [2:0]    rec_prot, err_code;
   logic [7:0]    rec_waits;
   logic [15:0]   txn_count;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   apb_monitor #(
      .AWIDTH  (AW),
      .DWIDTH  (DW),
      .SWIDTH  (SW),
      .DEPTH   (DEPTH),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .i_clk       (clk),
      .i_arst      (arst),
      .i_sel       (sel),
      .i_enable    (en),
      .i_write     (wr),
      .i_addr      (addr),
      .i_wdata     (wdata),
      .i_rdata     (rdata),
      .i_strb      (strb),
      .i_prot      (prot),
      .i_ready     (ready),
      .i_slverr    (slverr),
      .i_pop       (pop),
      .i_clrErr    (clr),
      .o_valid     (valid),
      .o_recWrite  (rec_write),
      .o_recAddr   (rec_addr),
      .o_recData   (rec_data),
      .o_recStrb   (rec_strb),
      .o_recProt   (rec_prot),
      .o_recSlvErr (rec_slverr),
      .o_recWaits  (rec_waits),
      .o_err       (err),
      .o_errCode   (err_code),
      .o_overflow  (overflow),
      .o_txnCount  (txn_count)
   );

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic idle();
      sel = 1'b0; en = 1'b0; ready = 1'b0; slverr = 1'b0;
   endtask

   task automatic pop_one();
      pop = 1'b1;
      cyc();
      pop = 1'b0;
   endtask

   task automatic pulse_clr();
      clr = 1'b1;
      cyc();
      clr = 1'b0;
   endtask

   // Leaves sel/enable high so another transfer can follow back-to-back.
   task automatic xfer(input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [SW-1:0] s,
                       input logic [2:0] p, input int waits,
                       input logic [DW-1:0] rd, input logic se,
                       input logic pop_end);
      sel = 1'b1; en = 1'b0; wr = w; addr = a; wdata = d;
      strb = s; prot = p; ready = 1'b0; slverr = 1'b0;
      rdata = 32'hBAD0_BAD0;
      cyc();
      en = 1'b1;
      repeat (waits) cyc();
      ready = 1'b1; rdata = rd; slverr = se; pop = pop_end;
      cyc();
      ready = 1'b0; slverr = 1'b0; pop = 1'b0;
   endtask

   initial begin
      cyc();
      cyc();
      check("rst valid", valid, 0);
      check("rst err", err, 0);
      check("rst code", err_code, 0);
      check("rst ovf", overflow, 0);
      check("rst txn", txn_count, 0);
      check("rst addr", rec_addr, 0);
      arst = 1'b0;
      cyc();

      // write, no waits
      xfer(1'b1, 12'h010, 32'hDEAD_BEEF, 4'hF, 3'd0, 0, 32'h0, 1'b0, 1'b0);
      idle();
      cyc();
      check("w valid", valid, 1);
      check("w dir", rec_write, 1);
      check("w addr", rec_addr, 32'h010);
      check("w data", rec_data, 32'hDEAD_BEEF);
      check("w strb", rec_strb, 4'hF);
      check("w waits", rec_waits, 0);
      check("w txn", txn_count, 1);
      check("w err", err, 0);
      pop_one();
      check("w popped", valid, 0);

      // read, 3 waits, slverr
      xfer(1'b0, 12'h020, 32'h0, 4'h0, 3'b010, 3, 32'h1234_5678, 1'b1, 1'b0);
      idle();
      cyc();
      check("r valid", valid, 1);
      check("r dir", rec_write, 0);
      check("r data", rec_data, 32'h1234_5678);
      check("r waits", rec_waits, 3);
      check("r slverr", rec_slverr, 1);
      check("r prot", rec_prot, 3'b010);
      check("r txn", txn_count, 2);
      pop_one();

      // enable without setup
      sel = 1'b1; en = 1'b1;
      cyc();
      idle();
      check("nosetup err", err, 1);
      check("nosetup code", err_code, 1);
      check("nosetup valid", valid, 0);

      // field change in access keeps first code
      sel = 1'b1; en = 1'b0; wr = 1'b1; addr = 12'h030;
      cyc();
      en = 1'b1;
      cyc();
      addr = 12'h034;
      cyc();
      idle();
      check("fchg err", err, 1);
      check("fchg code", err_code, 1);
      check("fchg valid", valid, 0);
      check("fchg txn", txn_count, 2);
      pulse_clr();
      check("clr err", err, 0);
      check("clr code", err_code, 0);

      // clear and violation together: violation wins
      clr = 1'b1; sel = 1'b1; en = 1'b1;
      cyc();
      clr = 1'b0;
      idle();
      check("clrviol err", err, 1);
      check("clrviol code", err_code, 1);
      pulse_clr();
      check("clr2 err", err, 0);

      // DEPTH+1 writes without pop
      for (int i = 0; i <= DEPTH; i++)
         xfer(1'b1, 12'(12'h100 + 4*i), 32'hA000_0000 + 32'(i), 4'hF,
              3'd0, 0, 32'h0, 1'b0, 1'b0);
      idle();
      cyc();
      check("ovf flag", overflow, 1);
      check("ovf txn", txn_count, DEPTH + 2 + 1);
      check("ovf err", err, 0);
      for (int i = 0; i < DEPTH; i++) begin
         check($sformatf("drain%0d addr", i), rec_addr, 12'h100 + 4*i);
         check($sformatf("drain%0d data", i), rec_data,
               32'hA000_0000 + 32'(i));
         pop_one();
      end
      check("drained", valid, 0);
      pulse_clr();
      check("ovf clr", overflow, 0);

      // push into full FIFO with a pop in the same cycle
      for (int i = 0; i < DEPTH; i++)
         xfer(1'b1, 12'(12'h200 + 4*i), 32'(i), 4'h1,
              3'd0, 0, 32'h0, 1'b0, 1'b0);
      xfer(1'b1, 12'h210, 32'h99, 4'h1, 3'd0, 0, 32'h0, 1'b0, 1'b1);
      idle();
      cyc();
      check("fullpop ovf", overflow, 0);
      check("fullpop txn", txn_count, 12);
      for (int i = 0; i < DEPTH; i++) begin
         check($sformatf("fp%0d addr", i), rec_addr, 12'h204 + 4*i);
         pop_one();
      end
      check("fp drained", valid, 0);

      // timeout
      sel = 1'b1; en = 1'b0; wr = 1'b0; addr = 12'h040;
      cyc();
      en = 1'b1;
      repeat (TIMEOUT - 1) cyc();
      check("pre-timeout err", err, 0);
      cyc();
      check("timeout err", err, 1);
      check("timeout code", err_code, 5);
      idle();
      cyc();
      check("timeout valid", valid, 0);
      check("timeout txn", txn_count, 12);
      pulse_clr();
      check("tclr err", err, 0);
      check("tclr code", err_code, 0);

      // reset in the middle of an access
      xfer(1'b1, 12'h050, 32'h5, 4'hF, 3'd0, 0, 32'h0, 1'b0, 1'b0);
      sel = 1'b1; en = 1'b1;
      cyc();
      idle();
      check("prerst err", err, 1);
      sel = 1'b1; en = 1'b0; wr = 1'b1; addr = 12'h060;
      cyc();
      en = 1'b1;
      cyc();
      cyc();
      arst = 1'b1;
      idle();
      #1;
      check("arst valid", valid, 0);
      check("arst err", err, 0);
      check("arst code", err_code, 0);
      check("arst txn", txn_count, 0);
      check("arst addr", rec_addr, 0);
      check("arst data", rec_data, 0);
      cyc();
      arst = 1'b0;
      cyc();
      xfer(1'b1, 12'h0AB, 32'h55AA_55AA, 4'h3, 3'b001, 0, 32'h0, 1'b0, 1'b0);
      idle();
      cyc();
      check("post valid", valid, 1);
      check("post addr", rec_addr, 12'h0AB);
      check("post data", rec_data, 32'h55AA_55AA);
      check("post strb", rec_strb, 4'h3);
      check("post waits", rec_waits, 0);
      check("post txn", txn_count, 1);
      check("post err", err, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
